// File: rtl/pwm_bank_pkg.sv
// Shared helpers for the pwm_bank slice: width math, period constants and duty clamping.
// Used by pwm_bank and pwm_bank_chan.
package pwm_bank_pkg;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned width;
      int unsigned rem;
      width = 0;
      rem   = (value > 0) ? value - 1 : 0;
      while (rem > 0) begin
         width++;
         rem = rem >> 1;
      end
      return width;
   endfunction

   // A single-channel bank still needs a one-bit channel select port.
   function automatic int unsigned ch_width(input int unsigned channels);
      return (clog2(channels) > 1) ? clog2(channels) : 1;
   endfunction

   function automatic int unsigned period_of(input int unsigned cnt_w);
      return 32'd1 << cnt_w;
   endfunction

   function automatic int unsigned cnt_max_of(input int unsigned cnt_w);
      return period_of(cnt_w) - 1;
   endfunction

   function automatic int unsigned clamp_duty(input int unsigned duty, input int unsigned period);
      return (duty > period) ? period : duty;
   endfunction

endpackage

// File: rtl/pwm_bank_chan.sv
// One PWM channel: pending/active duty double buffer plus period compare.
// Optional per-channel output polarity when PWM_BANK_POLARITY_EN is defined.
module pwm_bank_chan
   import pwm_bank_pkg::*;
#(
   parameter int CNT_W = 3
) (
   input  logic             clk_i,
   input  logic             clear_i,
   input  logic             wr_i,
   input  logic             boundary_i,
   input  logic [CNT_W:0]   duty_i,
`ifdef PWM_BANK_POLARITY_EN
   input  logic             pol_i,
`endif
   input  logic [CNT_W-1:0] cnt_i,
   output logic             pend_o,
   output logic             level_o
);

   logic [CNT_W:0] p_q, p_d;
   logic [CNT_W:0] a_q, a_d;
   logic           f_q, f_d;
   logic           cmp;

`ifdef PWM_BANK_POLARITY_EN
   logic pol_p_q, pol_p_d;
   logic pol_a_q, pol_a_d;
`endif

   // A write only reaches a channel whose flag is clear, so it never collides with a transfer.
   always_comb begin
      p_d = p_q;
      a_d = a_q;
      f_d = f_q;
`ifdef PWM_BANK_POLARITY_EN
      pol_p_d = pol_p_q;
      pol_a_d = pol_a_q;
`endif
      if (boundary_i && f_q) begin
         a_d = p_q;
         f_d = 1'b0;
`ifdef PWM_BANK_POLARITY_EN
         pol_a_d = pol_p_q;
`endif
      end
      if (wr_i) begin
         p_d = duty_i;
         f_d = 1'b1;
`ifdef PWM_BANK_POLARITY_EN
         pol_p_d = pol_i;
`endif
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge clear_i) begin
      if (clear_i) begin
         p_q <= '0;
         a_q <= '0;
         f_q <= 1'b0;
`ifdef PWM_BANK_POLARITY_EN
         pol_p_q <= 1'b0;
         pol_a_q <= 1'b0;
`endif
      end else begin
         p_q <= p_d;
         a_q <= a_d;
         f_q <= f_d;
`ifdef PWM_BANK_POLARITY_EN
         pol_p_q <= pol_p_d;
         pol_a_q <= pol_a_d;
`endif
      end
   end

   // Extra duty bit lets a full-period duty keep the output high for every position.
   assign cmp    = ({1'b0, cnt_i} < a_q);
   assign pend_o = f_q;

`ifdef PWM_BANK_POLARITY_EN
   assign level_o = cmp ^ pol_a_q;
`else
   assign level_o = cmp;
`endif

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: shared period counter, write handshake, registered outputs.
// Define PWM_BANK_POLARITY_EN to add the LOAD_POL input and per-channel output polarity.
module pwm_bank
   import pwm_bank_pkg::*;
#(
   parameter  int CNT_W    = 3,
   parameter  int CHANNELS = 4,
   localparam int CH_W     = ch_width(CHANNELS)
) (
   input  logic                CLK,
   input  logic                CLEAR,
   input  logic                EN,
   input  logic                LOAD_VALID,
   output logic                LOAD_READY,
   input  logic [CH_W-1:0]     LOAD_CH,
   input  logic [CNT_W:0]      LOAD_DUTY,
`ifdef PWM_BANK_POLARITY_EN
   input  logic                LOAD_POL,
`endif
   output logic                PERIOD_START,
   output logic [CHANNELS-1:0] O
);

   localparam int          DUTY_W  = CNT_W + 1;
   localparam int unsigned PERIOD  = period_of(CNT_W);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max_of(CNT_W));

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CHANNELS-1:0] o_q, o_d;
   logic                ps_q, ps_d;
   logic                boundary;
   logic [CHANNELS-1:0] wr;
   logic [CHANNELS-1:0] pend;
   logic [CHANNELS-1:0] level;
   logic [DUTY_W-1:0]   duty_clamped;

   assign boundary     = EN && (cnt_q == CNT_MAX);
   assign duty_clamped = DUTY_W'(clamp_duty(32'(LOAD_DUTY), PERIOD));

   // Channel selects beyond CHANNELS match no entry, so READY stays high and the write is dropped.
   always_comb begin
      LOAD_READY = 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
         if (LOAD_CH == CH_W'(i)) LOAD_READY = ~pend[i];
      end
   end

   always_comb begin
      wr = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         wr[i] = LOAD_VALID && LOAD_READY && (LOAD_CH == CH_W'(i));
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      pwm_bank_chan #(.CNT_W(CNT_W)) u_chan (
         .clk_i      (CLK),
         .clear_i    (CLEAR),
         .wr_i       (wr[i]),
         .boundary_i (boundary),
         .duty_i     (duty_clamped),
`ifdef PWM_BANK_POLARITY_EN
         .pol_i      (LOAD_POL),
`endif
         .cnt_i      (cnt_q),
         .pend_o     (pend[i]),
         .level_o    (level[i])
      );
   end

   // Outputs sample the compare for the current position, so they trail cnt by one edge.
   always_comb begin
      cnt_d = cnt_q;
      o_d   = o_q;
      ps_d  = ps_q;
      if (EN) begin
         cnt_d = cnt_q + 1'b1;
         o_d   = level;
         ps_d  = (cnt_q == '0);
      end
   end

   always_ff @(posedge CLK or posedge CLEAR) begin
      if (CLEAR) begin
         cnt_q <= '0;
         o_q   <= '0;
         ps_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         o_q   <= o_d;
         ps_q  <= ps_d;
      end
   end

   assign O            = o_q;
   assign PERIOD_START = ps_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank (CNT_W=3, CHANNELS=4): cycle model feeding a scoreboard
// queue, plus directed period-pattern checks.
module tb_pwm_bank;

   logic       CLK = 1'b0;
   logic       CLEAR;
   logic       EN;
   logic       LOAD_VALID;
   logic       LOAD_READY;
   logic [1:0] LOAD_CH;
   logic [3:0] LOAD_DUTY;
   logic       PERIOD_START;
   logic [3:0] O;
`ifdef PWM_BANK_POLARITY_EN
   logic       LOAD_POL = 1'b0;
`endif

   pwm_bank #(.CNT_W(3), .CHANNELS(4)) dut (
      .CLK          (CLK),
      .CLEAR        (CLEAR),
      .EN           (EN),
      .LOAD_VALID   (LOAD_VALID),
      .LOAD_READY   (LOAD_READY),
      .LOAD_CH      (LOAD_CH),
      .LOAD_DUTY    (LOAD_DUTY),
`ifdef PWM_BANK_POLARITY_EN
      .LOAD_POL     (LOAD_POL),
`endif
      .PERIOD_START (PERIOD_START),
      .O            (O)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [3:0] o;
      logic       ps;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [2:0] m_cnt;
   logic [3:0] m_a [4];
   logic [3:0] m_p [4];
   logic [3:0] m_f;
   logic [3:0] m_o;
   logic       m_ps;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = '0;
      m_f   = '0;
      m_o   = '0;
      m_ps  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         m_a[i] = '0;
         m_p[i] = '0;
      end
      sb_q.delete();
   endtask

   // One clock: check READY before the edge, predict the edge, compare after it.
   task automatic tick();
      logic acc;
      exp_t e;
      #1;
      check("load_ready", LOAD_READY, !m_f[LOAD_CH]);
      acc = LOAD_VALID && !m_f[LOAD_CH];
      if (EN) begin
         for (int i = 0; i < 4; i++) m_o[i] = ({1'b0, m_cnt} < m_a[i]);
         m_ps = (m_cnt == 3'd0);
         if (m_cnt == 3'd7) begin
            for (int i = 0; i < 4; i++) begin
               if (m_f[i]) begin
                  m_a[i] = m_p[i];
                  m_f[i] = 1'b0;
               end
            end
         end
         m_cnt = m_cnt + 3'd1;
      end
      if (acc) begin
         m_p[LOAD_CH] = (LOAD_DUTY > 4'd8) ? 4'd8 : LOAD_DUTY;
         m_f[LOAD_CH] = 1'b1;
      end
      sb_q.push_back('{o: m_o, ps: m_ps});
      @(posedge CLK);
      #1;
      e = sb_q.pop_front();
      check("o", O, e.o);
      check("period_start", PERIOD_START, e.ps);
   endtask

   task automatic load(input logic [1:0] ch, input logic [3:0] duty);
      LOAD_VALID = 1'b1;
      LOAD_CH    = ch;
      LOAD_DUTY  = duty;
      tick();
      LOAD_VALID = 1'b0;
   endtask

   task automatic align(input logic [2:0] pos);
      for (int k = 0; k < 16 && m_cnt != pos; k++) tick();
   endtask

   task automatic wait_ps();
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         if (PERIOD_START === 1'b1) seen = 1'b1;
      end
      check("ps_timeout", seen, 1);
   endtask

   task automatic capture_period(output logic [3:0][7:0] pats);
      wait_ps();
      for (int i = 0; i < 4; i++) pats[i] = {7'b0, O[i]};
      repeat (7) begin
         tick();
         for (int i = 0; i < 4; i++) pats[i] = {pats[i][6:0], O[i]};
      end
   endtask

   initial begin
      logic [3:0][7:0] pats;
      int   ps_cnt;
      logic [3:0] o_or;
      int   n;
      int   len;
      int   hi;

      CLEAR      = 1'b1;
      EN         = 1'b1;
      LOAD_VALID = 1'b0;
      LOAD_CH    = '0;
      LOAD_DUTY  = '0;
      model_reset();
      #1;
      check("reset_o", O, 4'b0000);
      check("reset_ps", PERIOD_START, 0);
      check("reset_ready", LOAD_READY, 1);
      repeat (2) @(posedge CLK);
      #1 CLEAR = 1'b0;

      // Idle bank: outputs low, one period start every 8 cycles.
      ps_cnt = 0;
      o_or   = '0;
      repeat (16) begin
         tick();
         ps_cnt += int'(PERIOD_START);
         o_or |= O;
      end
      check("idle_ps_count", ps_cnt, 2);
      check("idle_o", o_or, 4'b0000);

      // Duty 3 loaded mid-period shows up on the next period.
      align(3'd4);
      load(2'd0, 4'd3);
      capture_period(pats);
      check("ch0_duty3", pats[0], 8'b11100000);

      // 0%, 100% and clamped-over-range duties.
      load(2'd1, 4'd0);
      load(2'd2, 4'd8);
      load(2'd3, 4'd12);
      capture_period(pats);
      check("ch0_keeps_duty3", pats[0], 8'b11100000);
      check("ch1_duty0", pats[1], 8'h00);
      check("ch2_duty8", pats[2], 8'hFF);
      check("ch3_duty12_clamped", pats[3], 8'hFF);

      // Second write in one period is refused; READY returns after the boundary.
      align(3'd1);
      load(2'd0, 4'd5);
      LOAD_VALID = 1'b1;
      LOAD_CH    = 2'd0;
      LOAD_DUTY  = 4'd2;
      #1;
      check("second_write_ready", LOAD_READY, 0);
      tick();
      LOAD_VALID = 1'b0;
      n = 0;
      while (LOAD_READY !== 1'b1 && n < 16) begin
         tick();
         n++;
      end
      check("ready_return_cycles", n, 5);
      capture_period(pats);
      check("ch0_first_write_wins", pats[0], 8'b11111000);

      // EN low for 5 cycles at position 2 stretches the period to 13 cycles, 9 high.
      load(2'd0, 4'd4);
      wait_ps();
      len = 1;
      hi  = int'(O[0]);
      for (int k = 0; k < 40; k++) begin
         EN = (len >= 3 && len < 8) ? 1'b0 : 1'b1;
         tick();
         if (EN && PERIOD_START === 1'b1) break;
         len++;
         hi += int'(O[0]);
      end
      EN = 1'b1;
      check("stretched_period_len", len, 13);
      check("stretched_period_high", hi, 9);

      // Asynchronous clear mid-period drops the pending duty.
      load(2'd0, 4'd6);
      check("pre_clear_o0", O[0], 1);
      #1 CLEAR = 1'b1;
      #1;
      check("async_clear_o", O, 4'b0000);
      check("async_clear_ps", PERIOD_START, 0);
      check("async_clear_ready", LOAD_READY, 1);
      #1 CLEAR = 1'b0;
      model_reset();
      o_or = '0;
      repeat (16) begin
         tick();
         o_or |= O;
      end
      check("post_clear_o", o_or, 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_bank.md
# pwm_bank

Parametrised multi-channel PWM generator. A shared period counter runs over 2^CNT_W cycles, and each channel outputs a duty value taken from a double-buffered register. New duties are written through a valid/ready handshake and take effect only at a period boundary, so every period is glitch-free. The block generalises the 8-step fixed-pattern serial output path (3-bit counter plus duty pattern select) to any counter width, any channel count, full 0–100% duty range, and run/hold control.

## Interface
- CNT_W, 3: period counter width; period = 2^CNT_W enabled cycles.
- CHANNELS, 4: number of PWM outputs (≥1).
- CLK  in  1  sole clock, rising edge.
- CLEAR  in  1  reset, asynchronous, active-high.
- EN  in  1  count enable; low freezes counter and outputs.
- LOAD_VALID  in  1  duty write request.
- LOAD_READY  out  1  write accepted when VALID&READY at CLK edge.
- LOAD_CH  in  max(1,clog2(CHANNELS))  target channel.
- LOAD_DUTY  in  CNT_W+1  high cycles per period, 0..2^CNT_W.
- PERIOD_START  out  1  high in the cycle O shows period position 0.
- O  out  CHANNELS  PWM outputs, registered.

## Operation
- Counter cnt: 0..2^CNT_W−1, increments on each EN=1 edge, wraps to 0. The wrap edge is the period boundary.
- Per channel: active duty A[i] and pending duty P[i] with pending flag F[i].
- LOAD_READY = ~F[LOAD_CH]; combinational in LOAD_CH and state only.
- Accepted write sets P[LOAD_CH] = min(LOAD_DUTY, 2^CNT_W) and F=1. Out-of-range duty clamps to 100%. LOAD_CH ≥ CHANNELS: READY=1, write dropped.
- At period boundary, every channel with F=1 gets A←P, F←0. This happens in the same edge for all channels.
- O[i] high for the first A[i] cycles of each period. A=0 gives constant low; A=2^CNT_W gives constant high.
- Loads are accepted while EN=0, but no transfer happens until a boundary occurs.
- Write and boundary in the same cycle for a channel with F=1: READY is already 0, so no write; the transfer proceeds. READY=1 next cycle.

## Timing
- O and PERIOD_START are registered and lag cnt by one cycle. The first period after CLEAR deassert starts on the first EN=1 edge: O shows position 0 and PERIOD_START=1 from that edge.
- Load to output latency: the new duty appears at the first period start after acceptance, with at most 2^CNT_W enabled cycles plus one cycle delay.
- EN=0: cnt, O, PERIOD_START, A, F hold (PERIOD_START holds its value; it is not re-pulsed).
- Reset values (async on CLEAR rise): cnt=0, A=0, P=0, F=0, O=0, PERIOD_START=0, LOAD_READY=1 (for valid LOAD_CH). CLEAR mid-operation discards all pending writes.

## Configuration
- PWM_BANK_POLARITY_EN defined:
  - adds input LOAD_POL (1) captured with LOAD_DUTY into the pending register and transferred at the boundary.
  - O[i] = compare XOR active polarity.
  - polarity reset value 0.
- Undefined: no LOAD_POL port; outputs are always active-high.

## Structure
- Package pwm_bank_pkg:
  - clog2 function;
  - duty clamp function;
  - constants derived from CNT_W (PERIOD = 2^CNT_W, CNT_MAX).
- Sub-module pwm_bank_chan, one instance per channel via generate. It holds P/A/F (plus polarity) and the compare, and has inputs for write strobe, boundary strobe and cnt.
- Top level holds the counter, boundary detect, READY mux and PERIOD_START.

## Test plan
All scenarios use CNT_W=3, CHANNELS=4, EN=1 unless stated.
- CLEAR pulse then no loads -> O=0000 constant; PERIOD_START high 1 of every 8 cycles; LOAD_READY=1.
- Load ch0 duty 3 at cnt=4 -> O[0] stays 0 until the next PERIOD_START, then repeats 11100000.
- Load ch1=0, ch2=8, ch3=12 -> from the next period, O[1]=0 constant, O[2]=1 constant, O[3]=1 constant (clamped).
- Two writes to ch0 in one period -> second sees LOAD_READY=0 and is not accepted; READY returns to 1 the cycle after the boundary; first value takes effect.
- EN low 5 cycles at period position 2 with ch0 duty 4 -> O and cnt frozen; that period lasts 13 clock cycles with 9 high.
- CLEAR asserted mid-period with ch0 pending duty 6 -> O=0000 immediately (before the next edge); after release, ch0 stays 0 (pending discarded).
